// File: rtl/trivium_if.sv
// Keystream handshake bundle between the Trivium core and its consumer.
// The master drives rekey/key/IV/read; the core (slave) returns byte/valid/busy.
interface trivium_if;
   logic        rekey;
   logic [79:0] key_in;
   logic [79:0] iv_in;
   logic        keystream_read;
   logic [7:0]  keystream_byte;
   logic        keystream_valid;
   logic        busy;

   modport master (
      output rekey, key_in, iv_in, keystream_read,
      input  keystream_byte, keystream_valid, busy
   );

   modport slave (
      input  rekey, key_in, iv_in, keystream_read,
      output keystream_byte, keystream_valid, busy
   );
endinterface

// File: rtl/trivium_core.sv
// Trivium keystream generator: 8 rounds per clock, autonomous warm-up after
// reset or rekey, one LSB-first keystream byte per accepted read.
module trivium_core #(
   parameter logic [79:0] KEY           = 80'h0,
   parameter logic [79:0] IV            = 80'h0,
   parameter int          WARMUP_CYCLES = 144
) (
   input  logic      clk,
   input  logic      rst_n,
   trivium_if.slave  bus
);

   typedef enum logic [1:0] {
      WARMUP = 2'd0,
      PRIME  = 2'd1,
      READY  = 2'd2
   } state_t;

   localparam logic [7:0] LAST_CNT = 8'(WARMUP_CYCLES - 1);

   // Vector bit n-1 holds Trivium state bit s_n.
   function automatic logic [287:0] load_state(input logic [79:0] k, input logic [79:0] v);
      logic [287:0] s;
      s            = 288'd0;
      s[79:0]      = k;
      s[172:93]    = v;
      s[287:285]   = 3'b111;
      return s;
   endfunction

   state_t       fsm_r, fsm_s;
   logic [287:0] st_r, st_s, adv_s;
   logic [7:0]   z_s;
   logic [7:0]   cnt_r, cnt_s;
   logic [7:0]   byte_r, byte_s;
   logic         valid_r, valid_s;
   logic         busy_r, busy_s;

   // Eight chained Trivium rounds on the current state.
   always_comb begin
      logic [287:0] w;
      logic         t1, t2, t3;
      w   = st_r;
      z_s = 8'd0;
      for (int j = 0; j < 8; j++) begin
         t1     = w[65] ^ w[92];
         t2     = w[161] ^ w[176];
         t3     = w[242] ^ w[287];
         z_s[j] = t1 ^ t2 ^ t3;
         t1     = t1 ^ (w[90] & w[91]) ^ w[170];
         t2     = t2 ^ (w[174] & w[175]) ^ w[263];
         t3     = t3 ^ (w[285] & w[286]) ^ w[68];
         w      = {w[286:177], t2, w[175:93], t1, w[91:0], t3};
      end
      adv_s = w;
   end

   // Next-state and next-output selection; rekey overrides everything.
   always_comb begin
      fsm_s   = fsm_r;
      st_s    = st_r;
      cnt_s   = cnt_r;
      byte_s  = byte_r;
      valid_s = valid_r;
      if (bus.rekey) begin
         st_s    = load_state(bus.key_in, bus.iv_in);
         cnt_s   = 8'd0;
         fsm_s   = WARMUP;
         valid_s = 1'b0;
      end else begin
         case (fsm_r)
            WARMUP: begin
               st_s = adv_s;
               if (cnt_r == LAST_CNT) begin
                  fsm_s = PRIME;
               end else begin
                  cnt_s = cnt_r + 8'd1;
               end
            end
            PRIME: begin
               st_s    = adv_s;
               byte_s  = z_s;
               valid_s = 1'b1;
               fsm_s   = READY;
            end
            READY: begin
               if (bus.keystream_read) begin
                  st_s   = adv_s;
                  byte_s = z_s;
               end else begin
                  st_s   = st_r;
                  byte_s = byte_r;
               end
            end
            default: begin
               // Unreachable encoding: restart cleanly from the reset key.
               st_s    = load_state(KEY, IV);
               cnt_s   = 8'd0;
               fsm_s   = WARMUP;
               valid_s = 1'b0;
            end
         endcase
      end
      busy_s = (fsm_s != READY);
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_r   <= WARMUP;
         st_r    <= load_state(KEY, IV);
         cnt_r   <= 8'd0;
         byte_r  <= 8'h00;
         valid_r <= 1'b0;
         busy_r  <= 1'b1;
      end else begin
         fsm_r   <= fsm_s;
         st_r    <= st_s;
         cnt_r   <= cnt_s;
         byte_r  <= byte_s;
         valid_r <= valid_s;
         busy_r  <= busy_s;
      end
   end

   assign bus.keystream_byte  = byte_r;
   assign bus.keystream_valid = valid_r;
   assign bus.busy            = busy_r;

endmodule

// File: tb/tb_trivium_core.sv
// Self-checking bench for trivium_core against a bit-serial Trivium model.
module tb_trivium_core;
   localparam int W = 144;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   trivium_if bus();

   trivium_core #(.KEY(80'h0), .IV(80'h0), .WARMUP_CYCLES(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   bit         m [1:288];
   int         warm   = 0;
   logic       ev     = 1'b0;
   logic       eb     = 1'b1;
   logic [7:0] ebyte  = 8'h00;
   logic [7:0] junk;
   logic [7:0] b;
   int         n;
   int         drops;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_load(input logic [79:0] k, input logic [79:0] v);
      for (int i = 1; i <= 288; i++) m[i] = 1'b0;
      for (int i = 1; i <= 80; i++) begin
         m[i]      = k[i-1];
         m[93 + i] = v[i-1];
      end
      m[286] = 1'b1;
      m[287] = 1'b1;
      m[288] = 1'b1;
   endtask

   task automatic m_round(output bit z);
      bit t1, t2, t3;
      t1 = m[66] ^ m[93];
      t2 = m[162] ^ m[177];
      t3 = m[243] ^ m[288];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (m[91] & m[92]) ^ m[171];
      t2 = t2 ^ (m[175] & m[176]) ^ m[264];
      t3 = t3 ^ (m[286] & m[287]) ^ m[69];
      for (int i = 288; i > 178; i--) m[i] = m[i-1];
      m[178] = t2;
      for (int i = 177; i > 94; i--) m[i] = m[i-1];
      m[94] = t1;
      for (int i = 93; i > 1; i--) m[i] = m[i-1];
      m[1] = t3;
   endtask

   task automatic m_byte(output logic [7:0] by);
      bit z;
      by = 8'h00;
      for (int j = 0; j < 8; j++) begin
         m_round(z);
         by[j] = z;
      end
   endtask

   // Reference: what the consumer must observe, edge by edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_load(80'h0, 80'h0);
         warm  = 0;
         ev    = 1'b0;
         eb    = 1'b1;
         ebyte = 8'h00;
      end else if (bus.rekey) begin
         m_load(bus.key_in, bus.iv_in);
         warm = 0;
         ev   = 1'b0;
         eb   = 1'b1;
      end else if (warm < W) begin
         m_byte(junk);
         warm++;
      end else if (!ev) begin
         m_byte(ebyte);
         ev = 1'b1;
         eb = 1'b0;
      end else if (bus.keystream_read) begin
         m_byte(ebyte);
      end
   end

   // Compare outputs against the reference every cycle out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         check("valid", 32'(bus.keystream_valid), 32'(ev));
         check("busy",  32'(bus.busy),            32'(eb));
         check("byte",  32'(bus.keystream_byte),  32'(ebyte));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic measure(input bit rnd, output int cnt);
      cnt = 0;
      while (cnt < 300) begin
         @(posedge clk);
         cnt++;
         #1;
         if (bus.keystream_valid) break;
         if (rnd) bus.keystream_read = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic check_cleared(input string nm);
      check({nm, "_byte"},  32'(bus.keystream_byte),  32'h0);
      check({nm, "_valid"}, 32'(bus.keystream_valid), 32'h0);
      check({nm, "_busy"},  32'(bus.busy),            32'h1);
   endtask

   initial begin
      bus.rekey          = 1'b0;
      bus.keystream_read = 1'b0;
      bus.key_in         = 80'h0;
      bus.iv_in          = 80'h0;

      // Hand-derived anchors: zero key/IV raw stream starts 1,1,1 then zeros.
      m_load(80'h0, 80'h0);
      m_byte(b);
      check("pin_raw_byte0", 32'(b), 32'h07);
      m_byte(b);
      check("pin_raw_byte1", 32'(b), 32'h00);
      m_load(80'h1, {1'b1, 79'h0});
      check("pin_load", 32'({m[1], m[2], m[173], m[174], m[285], m[286], m[288]}), 32'b1010011);

      #1 rst_n = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      measure(1'b0, n);
      check("latency_reset", 32'(n), 32'd145);
      repeat (5) tick();

      // Full-rate read with a fixed key/IV.
      bus.key_in = 80'h0123456789ABCDEF0123;
      bus.iv_in  = 80'hFEDCBA9876543210FEDC;
      bus.rekey  = 1'b1;
      tick();
      bus.rekey  = 1'b0;
      measure(1'b0, n);
      check("latency_rekey", 32'(n), 32'd145);
      bus.keystream_read = 1'b1;
      drops = 0;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (!bus.keystream_valid) drops++;
      end
      check("valid_never_drops", 32'(drops), 32'd0);

      // Sparse random reads.
      for (int i = 0; i < 200; i++) begin
         bus.keystream_read = ($urandom_range(0, 99) < 30);
         tick();
      end

      // Rekey in the middle of a stream while reads continue.
      bus.keystream_read = 1'b1;
      repeat (10) tick();
      bus.key_in = {$urandom, $urandom, 16'($urandom)};
      bus.iv_in  = {$urandom, $urandom, 16'($urandom)};
      bus.rekey  = 1'b1;
      tick();
      bus.rekey  = 1'b0;
      #1;
      check("rekey_valid_low", 32'(bus.keystream_valid), 32'h0);
      check("rekey_busy_high", 32'(bus.busy), 32'h1);
      measure(1'b0, n);
      check("latency_rekey_mid", 32'(n), 32'd145);
      repeat (20) tick();
      bus.keystream_read = 1'b0;

      // Rekey held for several clocks keeps reloading.
      bus.rekey = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.key_in = {$urandom, $urandom, 16'($urandom)};
         bus.iv_in  = {$urandom, $urandom, 16'($urandom)};
         tick();
      end
      bus.rekey = 1'b0;
      measure(1'b0, n);
      check("latency_rekey_held", 32'(n), 32'd145);
      for (int i = 0; i < 50; i++) begin
         bus.keystream_read = ($urandom_range(0, 99) < 30);
         tick();
      end

      // Asynchronous reset in READY, then in WARMUP at count 70.
      bus.keystream_read = 1'b1;
      repeat (3) tick();
      #1 rst_n = 1'b0;
      #1 check_cleared("rst_ready");
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 70; i++) begin
         bus.keystream_read = 1'($urandom_range(0, 1));
         tick();
      end
      #1 rst_n = 1'b0;
      #1 check_cleared("rst_warmup");
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      measure(1'b1, n);
      check("latency_read_pulses", 32'(n), 32'd145);
      bus.keystream_read = 1'b1;
      repeat (8) tick();
      bus.keystream_read = 1'b0;
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
